// File: rtl/nand_seq_core.sv
// Two-op (NAND / relative branch) sequencer with a word-serial program loader.
// Define NAND_SEQ_STEP_EN to add step_mode/step single-step control ports.
module nand_seq_core #(
   parameter int DATA_W     = 1,
   parameter int ADDR_W     = 4,
   parameter int N_IN       = 2,
   parameter int N_OUT      = 7,
   parameter int N_INT      = 6,
   parameter int PC_W       = 10,
   parameter int IMEM_DEPTH = 1000,
   localparam int INSTR_W   = 1 + 3*ADDR_W
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [N_IN*DATA_W-1:0]    in_data,
   output logic [N_OUT*DATA_W-1:0]   out_data,
   input  logic                      load_start,
   input  logic                      load_valid,
   input  logic [INSTR_W-1:0]        load_data,
   output logic                      load_ready,
   input  logic                      run,
`ifdef NAND_SEQ_STEP_EN
   input  logic                      step_mode,
   input  logic                      step,
`endif
   output logic                      halted,
   output logic [PC_W-1:0]           pc
);

   localparam int NREG    = N_OUT + N_INT;
   localparam int IMEM_AW = (IMEM_DEPTH > 1) ? $clog2(IMEM_DEPTH) : 1;
   localparam int OFF_W   = 2*ADDR_W - 1;
   // One extra bit so load_addr can sit at IMEM_DEPTH once the memory is full.
   localparam int LA_W    = PC_W + 1;

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_HALT} state_t;

   state_t              state_q, state_d;
   logic [PC_W-1:0]     pc_q, pc_d;
   logic [LA_W-1:0]     load_addr_q, load_addr_d;
   logic                halted_q, halted_d;
   logic                load_ready_q, load_ready_d;
   logic [DATA_W-1:0]   regs_q [NREG];
   logic [DATA_W-1:0]   regs_d [NREG];
   logic [INSTR_W-1:0]  imem_q [IMEM_DEPTH];

   logic [INSTR_W-1:0]  instr;
   logic                op;
   logic [ADDR_W-1:0]   ra, f2, f3;
   logic [DATA_W-1:0]   rd_a, rd_b, nand_res;
   logic [OFF_W-1:0]    off;
   logic [PC_W-1:0]     off_pc, br_tgt;
   logic                taken, self_br, retire_en, load_accept;

   function automatic logic [DATA_W-1:0] rd_reg(input logic [ADDR_W-1:0] a);
      logic [DATA_W-1:0] v;
      v = '0;
      if (a == '0) v = '1;
      for (int i = 0; i < N_IN; i++)
         if (a == ADDR_W'(1 + i)) v = in_data[i*DATA_W +: DATA_W];
      for (int i = 0; i < NREG; i++)
         if (a == ADDR_W'(1 + N_IN + i)) v = regs_q[i];
      return v;
   endfunction

   // Fetch beyond the loaded depth yields the all-zero word, a halting self-branch.
   always_comb begin
      instr = '0;
      if ({1'b0, pc_q} < LA_W'(IMEM_DEPTH)) instr = imem_q[pc_q[IMEM_AW-1:0]];
   end

   assign op       = instr[0];
   assign ra       = instr[ADDR_W:1];
   assign f2       = instr[2*ADDR_W:ADDR_W+1];
   assign f3       = instr[3*ADDR_W:2*ADDR_W+1];
   assign rd_a     = rd_reg(ra);
   assign rd_b     = rd_reg(f2);
   assign nand_res = ~(rd_a & rd_b);
   assign off      = {f3, f2[ADDR_W-1:1]};
   assign off_pc   = PC_W'(off);
   assign br_tgt   = f2[0] ? (pc_q - off_pc) : (pc_q + off_pc);
   assign taken    = rd_a[0];
   assign self_br  = ~op & taken & (off == '0);

`ifdef NAND_SEQ_STEP_EN
   assign retire_en = ~step_mode | step;
`else
   assign retire_en = 1'b1;
`endif

   assign load_accept = (state_q == S_LOAD) && load_valid && load_ready_q;

   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      load_addr_d = load_addr_q;
      regs_d      = regs_q;
      if (load_start) begin
         state_d     = S_LOAD;
         load_addr_d = '0;
      end else begin
         case (state_q)
            S_IDLE: if (run) begin
               state_d = S_RUN;
               pc_d    = '0;
            end
            S_LOAD: begin
               if (load_accept) load_addr_d = load_addr_q + LA_W'(1);
               else if (run)    state_d     = S_IDLE;
            end
            S_RUN: begin
               if (run) begin
                  pc_d = '0;
               end else if (retire_en) begin
                  if (op) begin
                     pc_d = pc_q + PC_W'(1);
                     for (int i = 0; i < NREG; i++)
                        if (f3 == ADDR_W'(1 + N_IN + i)) regs_d[i] = nand_res;
                  end else if (self_br) begin
                     state_d = S_HALT;
                  end else if (taken) begin
                     pc_d = br_tgt;
                  end else begin
                     pc_d = pc_q + PC_W'(1);
                  end
               end
            end
            S_HALT: if (run) begin
               state_d = S_RUN;
               pc_d    = '0;
            end
            default: state_d = S_IDLE;
         endcase
      end
      halted_d     = (state_d == S_HALT);
      load_ready_d = (state_d == S_LOAD) && (load_addr_d < LA_W'(IMEM_DEPTH));
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= S_IDLE;
         pc_q         <= '0;
         load_addr_q  <= '0;
         halted_q     <= 1'b0;
         load_ready_q <= 1'b0;
         regs_q       <= '{default: '0};
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         load_addr_q  <= load_addr_d;
         halted_q     <= halted_d;
         load_ready_q <= load_ready_d;
         regs_q       <= regs_d;
      end
   end

   // Program memory survives reset.
   always_ff @(posedge clk) begin
      if (!reset && load_accept) imem_q[load_addr_q[IMEM_AW-1:0]] <= load_data;
   end

   for (genvar g = 0; g < N_OUT; g++) begin : g_out
      assign out_data[g*DATA_W +: DATA_W] = regs_q[g];
   end

   assign load_ready = load_ready_q;
   assign halted     = halted_q;
   assign pc         = pc_q;

endmodule

// File: tb/tb_nand_seq_core.sv
// Directed bench for nand_seq_core: scoreboard queue of expected values,
// checked with immediate assertions. Two instances: 1-bit/1024-deep and 4-bit/4-deep.
module tb_nand_seq_core;

   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic reset;

   logic [1:0]  in_data;
   logic [6:0]  out_data;
   logic        load_start, load_valid, load_ready, run, halted;
   logic [12:0] load_data;
   logic [9:0]  pc;

   nand_seq_core #(.IMEM_DEPTH(1024)) dut (
      .clk(clk), .reset(reset), .in_data(in_data), .out_data(out_data),
      .load_start(load_start), .load_valid(load_valid), .load_data(load_data),
      .load_ready(load_ready), .run(run), .halted(halted), .pc(pc));

   logic [7:0]  w_in;
   logic [27:0] w_out;
   logic        w_ls, w_lv, w_lr, w_run, w_halt;
   logic [12:0] w_ld;
   logic [9:0]  w_pc;

   nand_seq_core #(.DATA_W(4), .IMEM_DEPTH(4)) dutw (
      .clk(clk), .reset(reset), .in_data(w_in), .out_data(w_out),
      .load_start(w_ls), .load_valid(w_lv), .load_data(w_ld),
      .load_ready(w_lr), .run(w_run), .halted(w_halt), .pc(w_pc));

   typedef struct {
      string       tag;
      logic [31:0] val;
   } exp_t;

   exp_t        sb[$];
   int          n_checks = 0;
   int          n_fail   = 0;
   logic [12:0] prog [1024];
   logic [12:0] hs_w [3];
   bit          hs_v [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
   int          loop_pc [8] = '{1, 2, 3, 1, 2, 3, 4, 4};
   bit          loop_h  [8] = '{0, 0, 0, 0, 0, 0, 0, 1};
   int          wrap_pc [6] = '{1, 2, 1023, 0, 5, 5};
   bit          wrap_h  [6] = '{0, 0, 0, 0, 0, 1};
   int          k;
   logic        exp_n;

   function automatic logic [12:0] f_nand(input logic [3:0] ra, input logic [3:0] rb,
                                          input logic [3:0] rd);
      return {rd, rb, ra, 1'b1};
   endfunction

   function automatic logic [12:0] f_br(input logic [3:0] ra, input logic sub,
                                        input logic [6:0] off);
      return {off[6:3], off[2:0], sub, ra, 1'b0};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic sb_push(input string tag, input logic [31:0] v);
      exp_t e;
      e.tag = tag;
      e.val = v;
      sb.push_back(e);
   endtask

   task automatic observe(input logic [31:0] obs);
      exp_t e;
      n_checks++;
      if (sb.size() == 0) begin
         n_fail++;
         $error("FAIL scoreboard_empty observed=%0h", obs);
      end else begin
         e = sb.pop_front();
         assert (obs === e.val) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.val);
         end
      end
   endtask

   task automatic load_main(input int n);
      load_start = 1'b1; tick(); load_start = 1'b0;
      for (int i = 0; i < n; i++) begin
         load_valid = 1'b1;
         load_data  = prog[i];
         tick();
      end
      load_valid = 1'b0;
      run = 1'b1; tick(); run = 1'b0;
   endtask

   task automatic go_main();
      run = 1'b1; tick(); run = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      in_data = '0; load_start = 0; load_valid = 0; load_data = '0; run = 0;
      w_in = '0; w_ls = 0; w_lv = 0; w_ld = '0; w_run = 0;
      tick(); tick();
      sb_push("rst_halted", 0); sb_push("rst_ready", 0);
      sb_push("rst_pc", 0);     sb_push("rst_out", 0);
      reset = 1'b0;
      observe(32'(halted)); observe(32'(load_ready)); observe(32'(pc)); observe(32'(out_data));

      // load handshake with a bubble in load_valid
      hs_w[0] = f_nand(4'd1, 4'd2, 4'd3);
      hs_w[1] = 13'h0;
      hs_w[2] = f_nand(4'd0, 4'd0, 4'd4);
      load_start = 1'b1; tick(); load_start = 1'b0;
      k = 0;
      for (int c = 0; c < 4; c++) begin
         load_valid = hs_v[c];
         load_data  = hs_v[c] ? hs_w[k] : 13'h1fff;
         sb_push("hs_ready", 1);
         observe(32'(load_ready));
         tick();
         if (hs_v[c]) k++;
      end
      load_valid = 1'b0;
      for (int i = 0; i < 3; i++) sb_push("hs_imem", 32'(hs_w[i]));
      observe(32'(dut.imem_q[0])); observe(32'(dut.imem_q[1])); observe(32'(dut.imem_q[2]));
      run = 1'b1; tick(); run = 1'b0;
      sb_push("idle_ready", 0);
      observe(32'(load_ready));

      // NAND truth table, one run per input pattern
      for (int v = 0; v < 4; v++) begin
         in_data = 2'(v);
         exp_n = ~(in_data[0] & in_data[1]);
         go_main();
         sb_push("tt_halt0", 0);
         observe(32'(halted));
         tick(); tick();
         sb_push("tt_halt1", 1); sb_push("tt_out", 32'(exp_n)); sb_push("tt_pc", 1);
         observe(32'(halted)); observe(32'(out_data[0])); observe(32'(pc));
      end

      // backward loop: toggle R10, subtract-branch by 2 while R10 is set
      prog[0] = f_nand(4'd0, 4'd0, 4'd10);
      prog[1] = f_nand(4'd10, 4'd10, 4'd10);
      prog[2] = f_nand(4'd0, 4'd10, 4'd3);
      prog[3] = f_br(4'd10, 1'b1, 7'd2);
      prog[4] = 13'h0;
      load_main(5);
      go_main();
      for (int i = 0; i < 8; i++) begin
         sb_push("loop_pc", 32'(loop_pc[i]));
         sb_push("loop_halt", 32'(loop_h[i]));
         tick();
         observe(32'(pc)); observe(32'(halted));
      end
      sb_push("loop_out", 32'h1);
      observe(32'(out_data));

      // reset in the middle of a run
      go_main(); tick(); tick();
      sb_push("pre_rst_out", 32'h1);
      observe(32'(out_data));
      reset = 1'b1; tick(); reset = 1'b0;
      sb_push("mid_rst_out", 0); sb_push("mid_rst_pc", 0);
      sb_push("mid_rst_halt", 0); sb_push("mid_rst_ready", 0);
      observe(32'(out_data)); observe(32'(pc)); observe(32'(halted)); observe(32'(load_ready));
      tick(); tick(); tick();
      sb_push("idle_pc", 0); sb_push("idle_halt", 0);
      observe(32'(pc)); observe(32'(halted));

      // full 1024-word load, overflow refusal, then PC wrap in both directions
      for (int i = 0; i < 1024; i++) prog[i] = 13'h0;
      prog[0]    = f_br(4'd10, 1'b0, 7'd5);
      prog[1]    = f_nand(4'd10, 4'd10, 4'd10);
      prog[2]    = f_br(4'd0, 1'b1, 7'd3);
      prog[1023] = f_br(4'd0, 1'b0, 7'd1);
      load_start = 1'b1; tick(); load_start = 1'b0;
      for (int i = 0; i < 1024; i++) begin
         load_valid = 1'b1;
         load_data  = prog[i];
         tick();
      end
      sb_push("full_ready", 0);
      observe(32'(load_ready));
      load_data = 13'h1fff;
      tick();
      load_valid = 1'b0;
      sb_push("full_imem0", 32'(prog[0])); sb_push("full_imem1023", 32'(prog[1023]));
      observe(32'(dut.imem_q[0])); observe(32'(dut.imem_q[1023]));
      run = 1'b1; tick(); run = 1'b0;
      go_main();
      for (int i = 0; i < 6; i++) begin
         sb_push("wrap_pc", 32'(wrap_pc[i]));
         sb_push("wrap_halt", 32'(wrap_h[i]));
         tick();
         observe(32'(pc)); observe(32'(halted));
      end

      // 4-bit wide instance: depth-4 overflow, bitwise NAND, fall-off halt
      w_in = 8'h6A;
      w_ls = 1'b1; tick(); w_ls = 1'b0;
      for (int i = 0; i < 5; i++) begin
         case (i)
            0: w_ld = f_nand(4'd1, 4'd2, 4'd3);
            1: w_ld = f_nand(4'd3, 4'd3, 4'd11);
            2: w_ld = f_nand(4'd11, 4'd0, 4'd4);
            3: w_ld = f_nand(4'd1, 4'd0, 4'd5);
            default: w_ld = f_nand(4'd0, 4'd0, 4'd6);
         endcase
         w_lv = 1'b1;
         sb_push("w_ready", (i < 4) ? 1 : 0);
         observe(32'(w_lr));
         tick();
      end
      w_lv = 1'b0;
      sb_push("w_ready_end", 0);
      observe(32'(w_lr));
      w_run = 1'b1; tick(); w_run = 1'b0;
      w_run = 1'b1; tick(); w_run = 1'b0;
      for (int i = 0; i < 5; i++) begin
         sb_push("w_pc", (i < 4) ? 32'(i + 1) : 32'd4);
         sb_push("w_halt", (i == 4) ? 1 : 0);
         tick();
         observe(32'(w_pc)); observe(32'(w_halt));
      end
      sb_push("w_out", 32'h00005DD);
      observe(32'(w_out));

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/nand_seq_core.md
Name: nand_seq_core

Overview:
- Parametrised successor to the team's single-bit NAND sequencer.
- Executes a two-op ISA (bitwise NAND, relative conditional branch) over DATA_W-bit registers.
- Adds a word-serial valid/ready program loader, an explicit IDLE/LOAD/RUN/HALT state machine, and a self-branch halt.
- Sits between the board pins and the top wrapper; inputs come from pins, outputs drive pins.

Parameters:
- DATA_W, 1, register width in bits; NAND is bitwise across the word.
- ADDR_W, 4, register address width; 2^ADDR_W register slots.
- N_IN, 2, number of read-only input registers.
- N_OUT, 7, number of output registers.
- N_INT, 6, number of internal scratch registers; 1+N_IN+N_OUT+N_INT <= 2^ADDR_W.
- PC_W, 10, program counter width.
- IMEM_DEPTH, 1000, instruction words; must be <= 2^PC_W.
- INSTR_W is derived as 1+3*ADDR_W (localparam, not overridable).

Ports:
- clk, input, 1, clock.
- reset, input, 1, synchronous, active-high.
- in_data, input, N_IN*DATA_W, input registers; slot k is bits [k*DATA_W +: DATA_W].
- out_data, output, N_OUT*DATA_W, output registers, packed the same way.
- load_start, input, 1, pulse; enter LOAD with load address 0.
- load_valid, input, 1, load word present.
- load_data, input, INSTR_W, instruction word to store.
- load_ready, output, 1, core accepts a load word this cycle.
- run, input, 1, pulse; start execution at PC 0.
- halted, output, 1, high in HALT.
- pc, output, PC_W, current program counter.

Behaviour:
- Register map:
  - Address 0 reads all-ones.
  - Addresses 1..N_IN read inputs.
  - The next N_OUT addresses are outputs.
  - The next N_INT addresses are internal registers.
  - Unmapped addresses read 0; writes to address 0, inputs or unmapped addresses are ignored.
- Instruction fields: op = bit 0; ra = [ADDR_W:1]; f2 = [2*ADDR_W:ADDR_W+1]; f3 = [3*ADDR_W:2*ADDR_W+1].
- op=1, NAND: f3 <- ~(R[ra] & R[f2]); pc <- pc+1. The result is written at the clock edge ending the execute cycle.
- op=0, BRANCH:
  - Taken if bit 0 of R[ra] is 1.
  - Direction = f2[0] (0 add, 1 subtract); offset = {f3, f2[ADDR_W-1:1]}, zero-extended to PC_W.
  - Taken: pc <- pc ± offset. Not taken: pc <- pc+1.
  - PC arithmetic wraps modulo 2^PC_W.
- One instruction retires per clock in RUN. Fetch is combinational from pc; there is no pipeline and no hazards.
- Fetch at pc >= IMEM_DEPTH returns all-zero. The all-zero word is an always-taken branch with offset 0, so the core halts.
- A taken branch with offset 0 moves the FSM to HALT on that edge; pc holds.
- FSM states and transitions:
  - IDLE -> LOAD on load_start.
  - IDLE -> RUN on run, with pc <- 0.
  - LOAD: load_ready = (load_addr < IMEM_DEPTH). On load_valid && load_ready, imem[load_addr] <- load_data and load_addr increments.
  - LOAD -> IDLE on run with no write that cycle; the next run pulse starts execution.
  - load_start in any state -> LOAD with load_addr <- 0. This has priority over run.
  - RUN -> HALT on self-branch.
  - HALT -> RUN on run, with pc <- 0.
  - run while in RUN restarts at pc 0; registers are not cleared.
- load_ready is 0 outside LOAD.
- Register writes occur only in RUN.
- Reset, including mid-load or mid-run:
  - State <- IDLE; pc, load_addr <- 0.
  - All out/internal registers <- 0; halted <- 0; load_ready <- 0.
  - imem is not cleared.

Optional Feature:
- Macro NAND_SEQ_STEP_EN.
- Defined: adds input ports step_mode and step (1 bit each). When step_mode=1 in RUN, an instruction retires only on cycles with step=1; otherwise pc and registers hold. step_mode=0 runs every cycle.
- Undefined: these ports are absent and the core retires every RUN cycle.

Test Plan:
- Load-handshake check: reset, load_start, then 3 words with load_valid toggling 1,0,1,1 -> exactly 3 imem writes at addresses 0..2; load_ready=1 throughout LOAD.
- NAND truth table:
  - DATA_W=1; program NAND R1,R2->R3, then self-branch on R0.
  - Sweep in_data 00/01/10/11 with a run pulse for each value -> out_data[0] = 1,1,1,0.
  - halted=1 two cycles after each run.
- Backward loop: a counting loop using subtract-branch, offset 2, conditioned on an internal reg -> pc sequence repeats; taken/not-taken exits at the expected cycle; pc wraps 1023 -> 0 when jumping +1 from 1023.
- Bitwise NAND width: DATA_W=4, in0=4'hA, in1=4'h6 -> out0 = 4'hD.
- Fall-off: program of 2 NAND words with no halt -> pc reaches 2, fetches zero word, halted=1 with pc=2.
- Reset mid-run and load-overflow:
  - Reset asserted during RUN -> all outputs 0 and state IDLE the next cycle.
  - IMEM_DEPTH=4: 5 valid words offered -> load_ready drops after the 4th; the 5th word is not written.
